gpio_input_conditioner: RTL
===========================

// Module: gpio_input_conditioner
// PURPOSE
// - Parametrised conditioner for raw board inputs (push buttons, slide switches)
//   ahead of the SweRVolf GPIO/interrupt logic on the Nexys A7 top level.
// - Replaces direct wiring of raw pad levels into GPIO inputs.
// - Per channel: 2-FF synchroniser, tick-based debounce, rise/fall pulses,
//   sticky per-channel pending bits with mask and edge select, one IRQ line.
// PARAMETERS
// - N_CH            5   number of input channels (1..32)
// - TICK_DIV        50000  prescaler; one debounce tick every TICK_DIV clocks (>=1)
// - DEBOUNCE_TICKS  10  consecutive ticks of a differing input before level flips (>=1)
// - RESET_LEVEL     '0  [N_CH-1:0] stable level loaded at reset
// PORTS
// - i_clk        in   1        core clock (clk_core domain)
// - i_rst        in   1        reset; asynchronous, active-high
// - i_raw        in   N_CH     unsynchronised pad levels
// - i_edge_mode  in   2*N_CH   per channel {fall_en, rise_en}, ch k at [2k+1:2k]
// - i_irq_mask   in   N_CH     1 = pending bit may drive o_irq
// - i_clr_valid  in   1        qualifies i_clr_mask for one cycle
// - i_clr_mask   in   N_CH     pending bits to clear (write-1-to-clear)
// - o_level      out  N_CH     debounced stable level
// - o_rise       out  N_CH     1-cycle pulse: debounced 0->1
// - o_fall       out  N_CH     1-cycle pulse: debounced 1->0
// - o_pending    out  N_CH     sticky event flags
// - o_irq        out  1        |(o_pending & i_irq_mask), registered
// BEHAVIOUR
// - Reset (async, i_rst=1): sync FFs <= RESET_LEVEL, o_level <= RESET_LEVEL,
//   counters/prescaler <= 0, o_rise/o_fall/o_pending/o_irq <= 0.
// - Sync: 2 FFs per channel; s = second-stage output. No reset-release pulse.
// - Prescaler: shared counter 0..TICK_DIV-1; tick=1 in the cycle it equals
//   TICK_DIV-1, then wraps to 0. TICK_DIV=1 -> tick every cycle.
// - Debounce per channel (cnt width $clog2(DEBOUNCE_TICKS+1)):
//   * s == o_level: cnt <= 0 in that cycle (any bounce restarts the count).
//   * s != o_level, tick, cnt == DEBOUNCE_TICKS-1: o_level <= s, cnt <= 0,
//     o_rise/o_fall <= 1 for exactly one cycle (same cycle o_level changes).
//   * s != o_level, tick, otherwise: cnt <= cnt+1. No tick: cnt holds.
// - Latency (TICK_DIV=1): o_level changes 2+DEBOUNCE_TICKS cycles after the
//   first i_raw-sampling edge that sees the new value.
// - Pending: set_k = (o_rise[k]&rise_en_k)|(o_fall[k]&fall_en_k), using
//   registered pulses, so pending rises the cycle after the pulse.
//   clr_k = i_clr_valid & i_clr_mask[k]. pending <= (pending & ~clr) | set;
//   set wins over simultaneous clear. Mode change never clears pending.
// - o_irq registered from the next-state pending & i_irq_mask: follows
//   pending in the same cycle; drops the cycle a clear takes effect.
// - Mask affects only o_irq; masked channels still latch pending.
// - Reset mid-debounce: all state discarded immediately; after release the
//   channel restarts from RESET_LEVEL with cnt=0.
// STRUCTURE
// - Package rvfpga_io_pkg: edge_mode_e {EDGE_NONE=2'b00, EDGE_RISE=2'b01,
//   EDGE_FALL=2'b10, EDGE_BOTH=2'b11}; MAX_IO_CH=32.
// - Sub-module gpio_debounce_ch: sync + counter + level + pulses for one channel,
//   generated N_CH times. Top holds prescaler, pending register, IRQ reduce.
// TESTING (N_CH=4, TICK_DIV=1, DEBOUNCE_TICKS=4, RESET_LEVEL=4'b0000)
// - Reset: assert i_rst with i_raw=4'hF -> all outputs 0 async; after release
//   i_raw held 0 -> no pulses, o_level stays 4'h0.
// - Clean step: i_raw[0] 0->1 held -> o_level[0]=1 and o_rise[0] 1-cycle pulse
//   exactly 6 cycles after first sampling edge; o_fall stays 0.
// - Bounce: i_raw[1] high 3 cycles, low 1, high 3, low -> o_level[1] never
//   changes, no pulse; then high 6 cycles -> single rise.
// - Edge select: ch2 mode EDGE_FALL, mask[2]=1; rise -> pending[2]=0; fall ->
//   pending[2]=1 and o_irq=1; clear 4'b0100 -> both 0 next cycle.
// - Set/clear collision: clear pending[3] in same cycle a qualifying set on ch3
//   -> pending[3] stays 1, o_irq remains 1 if mask[3]=1.
// - Prescaler: TICK_DIV=3 -> stable change after 2+4*3(+phase<=2) cycles;
//   async reset mid-count -> outputs 0 immediately, no late pulse.

Source files
------------

// File: rtl/rvfpga_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rvfpga_io_pkg
//  Description : Shared types and limits for the board-input conditioning
//                blocks in front of the GPIO / interrupt logic.
//                edge_mode_e selects which debounced edges latch a pending bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package rvfpga_io_pkg;

    localparam int MAX_IO_CH = 32;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic mode_rise_en(input edge_mode_e mode);
        return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    endfunction

    function automatic logic mode_fall_en(input edge_mode_e mode);
        return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_debounce_ch
//  Description : One input channel: 2-FF synchroniser, tick-based debounce
//                counter, debounced level and one-cycle rise/fall pulses.
//  Ports       : i_clk   core clock
//                i_rst   asynchronous active-high reset
//                i_raw   unsynchronised pad level
//                i_tick  shared debounce tick (one cycle wide)
//                o_level debounced stable level
//                o_rise  one-cycle pulse on debounced 0->1
//                o_fall  one-cycle pulse on debounced 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce_ch #(
    parameter int   DEBOUNCE_TICKS = 10,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int                c_CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_TICKS - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_level;
    logic               r_rise;
    logic               r_fall;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_done;

    // The synchroniser resets to the same level as the debounced output so
    // that releasing reset never looks like an input change.
    always_comb begin
        w_diff = r_sync ^ r_level;
        w_done = w_diff & i_tick & (r_cnt == c_CNT_LAST);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta  <= RESET_LEVEL;
            r_sync  <= RESET_LEVEL;
            r_level <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_rise <= w_done &  r_sync;
            r_fall <= w_done & ~r_sync;
            if (w_done) begin
                r_level <= r_sync;
            end
            // Any cycle where the input agrees with the stable level restarts
            // the count, so a single bounce forces a full new qualification.
            if (!w_diff || w_done) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_input_conditioner
//  Description : Conditions raw push-button / switch inputs for the GPIO and
//                interrupt logic. Per channel debounce (gpio_debounce_ch),
//                shared tick prescaler, sticky pending bits with per-channel
//                edge select and write-1-to-clear, and one registered IRQ.
//  Ports       : i_clk       core clock (clk_core domain)
//                i_rst       asynchronous active-high reset
//                i_raw       [N_CH]   unsynchronised pad levels
//                i_edge_mode [2*N_CH] per channel {fall_en, rise_en}
//                i_irq_mask  [N_CH]   1 = pending bit may drive o_irq
//                i_clr_valid          qualifies i_clr_mask
//                i_clr_mask  [N_CH]   pending bits to clear
//                o_level     [N_CH]   debounced level
//                o_rise      [N_CH]   one-cycle debounced 0->1 pulse
//                o_fall      [N_CH]   one-cycle debounced 1->0 pulse
//                o_pending   [N_CH]   sticky event flags
//                o_irq                |(pending & mask), registered
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_input_conditioner
    import rvfpga_io_pkg::*;
#(
    parameter int              N_CH           = 5,
    parameter int              TICK_DIV       = 50000,
    parameter int              DEBOUNCE_TICKS = 10,
    parameter logic [N_CH-1:0] RESET_LEVEL    = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH-1:0]   i_raw,
    input  logic [2*N_CH-1:0] i_edge_mode,
    input  logic [N_CH-1:0]   i_irq_mask,
    input  logic              i_clr_valid,
    input  logic [N_CH-1:0]   i_clr_mask,
    output logic [N_CH-1:0]   o_level,
    output logic [N_CH-1:0]   o_rise,
    output logic [N_CH-1:0]   o_fall,
    output logic [N_CH-1:0]   o_pending,
    output logic              o_irq
);

    localparam int                   c_PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);

    logic [c_PRESC_W-1:0] r_presc;
    logic                 w_tick;

    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic [N_CH-1:0] w_rise_en;
    logic [N_CH-1:0] w_fall_en;

    logic [N_CH-1:0] r_pend;
    logic            r_irq;
    logic [N_CH-1:0] w_set;
    logic [N_CH-1:0] w_clr;
    logic [N_CH-1:0] w_pend_nxt;

    // ------------------------------------------------------------------------
    // Shared prescaler. With TICK_DIV = 1 the counter is pinned at zero and
    // the tick is asserted every cycle.
    // ------------------------------------------------------------------------
    assign w_tick = (r_presc == c_PRESC_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel debounce and edge-mode decode.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        edge_mode_e w_mode;

        assign w_mode       = edge_mode_e'(i_edge_mode[2*k +: 2]);
        assign w_rise_en[k] = mode_rise_en(w_mode);
        assign w_fall_en[k] = mode_fall_en(w_mode);

        gpio_debounce_ch #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .RESET_LEVEL    (RESET_LEVEL[k])
        ) u_debounce (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (i_raw[k]),
            .i_tick  (w_tick),
            .o_level (w_level[k]),
            .o_rise  (w_rise[k]),
            .o_fall  (w_fall[k])
        );
    end

    // ------------------------------------------------------------------------
    // Pending bits. Sets come from the registered pulses, so a pending bit
    // rises one cycle after its pulse. A set beats a simultaneous clear so an
    // event arriving while software clears the previous one is never lost.
    // ------------------------------------------------------------------------
    always_comb begin
        w_clr      = i_clr_valid ? i_clr_mask : '0;
        w_set      = (w_rise & w_rise_en) | (w_fall & w_fall_en);
        w_pend_nxt = (r_pend & ~w_clr) | w_set;
    end

    // The IRQ is built from the next-state pending vector so it tracks the
    // pending register in the same cycle instead of lagging it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_irq  <= |(w_pend_nxt & i_irq_mask);
        end
    end

    assign o_level   = w_level;
    assign o_rise    = w_rise;
    assign o_fall    = w_fall;
    assign o_pending = r_pend;
    assign o_irq     = r_irq;

endmodule
`default_nettype wire
